pmem_burst_responder: RTL and testbench
=======================================

Name: pmem_burst_responder

Overview:
- Physical-memory-side responder for the cache line interface (pmem_read/pmem_write/pmem_addr/pmem_wdata/pmem_rdata/pmem_resp).
- Accepts one full-line read or write from a cache. Executes it as a fixed-length burst of narrow beats on a burst memory port.
- Returns a single-cycle pmem_resp when the line transfer completes.
- Sits between the L1 caches (or their arbiter) and the burst DRAM model.

Parameters:
- s_offset, 5, byte-offset bits within a line; line is 2**s_offset bytes.
- s_line, 256, line width in bits (8*2**s_offset).
- s_beat, 64, burst beat width in bits.
- num_beats, s_line/s_beat (4), beats per burst; must be a power of two ≥2.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- pmem_read  in  1  line read request; held until pmem_resp.
- pmem_write  in  1  line write request; held until pmem_resp.
- pmem_addr  in  32  line address; low s_offset bits ignored.
- pmem_wdata  in  s_line  write line; stable while pmem_write is high.
- pmem_rdata  out  s_line  assembled read line; valid when pmem_resp is high after a read.
- pmem_resp  out  1  one-cycle completion pulse.
- burst_read  out  1  burst read request to memory.
- burst_write  out  1  burst write request to memory.
- burst_addr  out  32  line-aligned burst address (low s_offset bits = 0).
- burst_wdata  out  s_beat  current write beat.
- burst_rdata  in  s_beat  current read beat; valid when burst_resp is high.
- burst_resp  in  1  beat accept/valid strobe from memory.

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0, pmem_resp=0, burst_read=0, burst_write=0, burst_addr=0, burst_wdata=0, pmem_rdata=0.
- All outputs are registered.
- States: IDLE, RD_BURST, WR_BURST, RESP.
- IDLE:
  - pmem_write=1 → WR_BURST. Latch pmem_addr with low s_offset bits cleared into burst_addr. Latch pmem_wdata into the line buffer. burst_write=1 and burst_wdata=beat 0 (bits s_beat-1:0) from the next cycle.
  - Else pmem_read=1 → RD_BURST. Latch the aligned address. burst_read=1 from the next cycle.
  - Simultaneous read and write: write wins; the read is not serviced for that transaction.
- RD_BURST:
  - Each cycle with burst_resp=1, store burst_rdata into pmem_rdata slice [counter*s_beat +: s_beat] and increment the counter.
  - Beat 0 maps to the least-significant slice.
  - Cycles with burst_resp=0 (gaps) hold all state.
  - On the num_beats-th beat: clear burst_read and go to RESP.
- WR_BURST:
  - burst_wdata presents slice [counter*s_beat +: s_beat] of the latched line.
  - Each burst_resp=1 advances the counter; burst_wdata updates the next cycle.
  - On the final beat: clear burst_write and go to RESP.
- RESP:
  - pmem_resp=1 for exactly one cycle. The counter is back at 0 (it wraps at num_beats). Next state is IDLE.
  - pmem_rdata holds its value until the next read burst writes beat 0. Write transactions do not modify pmem_rdata.
- The requester drops its request the cycle after pmem_resp. A request visible in IDLE is therefore always new; back-to-back transactions start with zero extra idle cycles.
- Latency: request sampled in IDLE at cycle N → burst_* asserted at N+1. Final burst_resp at cycle M → pmem_resp at M+1. Minimum end-to-end latency is num_beats+2 cycles.
- burst_addr, burst_read and burst_write stay stable throughout the burst regardless of changes on pmem_* inputs. pmem_addr and pmem_wdata are only sampled in IDLE.
- burst_resp asserted while in IDLE or RESP is ignored.
- Reset mid-burst aborts immediately with no pmem_resp. A partially assembled pmem_rdata is cleared to 0.

Test Plan:
- Read: pmem_read=1, pmem_addr=0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles → burst_addr=0x0000_1220. pmem_rdata={44..,33..,22..,11..}. Single pmem_resp 1 cycle after beat 4, total 6 cycles.
- Write: pmem_write=1, pmem_addr=0x8000_003F, pmem_wdata=256'h{D,C,B,A} 64-bit words → burst_addr=0x8000_0020. burst_wdata sequence A,B,C,D, each held until its burst_resp. pmem_rdata unchanged.
- Stalled beats: read with burst_resp high only on cycles 1,4,5,9 → exactly 4 beats captured in order. pmem_resp exactly 1 cycle after cycle 9. burst_read high continuously until the final beat.
- Write-back then allocate (dirty-miss sequence): write to 0x100 followed immediately by read to 0x200 → two bursts, two pmem_resp pulses, no spurious third transaction. Read data correct.
- Async reset asserted after beat 2 of a read → all outputs 0 within the same cycle, no pmem_resp. A subsequent read completes normally with a fresh beat count.
- Simultaneous pmem_read=1 and pmem_write=1 → only burst_write is issued. Stray burst_resp in IDLE → no state change.

Source files
------------

// File: rtl/pmem_burst_responder.sv
// Line-to-burst bridge: turns one cache-line read/write into num_beats narrow
// beats on the burst port and pulses pmem_resp once the whole line has moved.
module pmem_burst_responder #(
   parameter int s_offset  = 5,
   parameter int s_line    = 256,
   parameter int s_beat    = 64,
   parameter int num_beats = s_line / s_beat
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [31:0]       pmem_addr,
   input  logic [s_line-1:0] pmem_wdata,
   output logic [s_line-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              burst_read,
   output logic              burst_write,
   output logic [31:0]       burst_addr,
   output logic [s_beat-1:0] burst_wdata,
   input  logic [s_beat-1:0] burst_rdata,
   input  logic              burst_resp
);
   localparam int cw = $clog2(num_beats);
   localparam logic [cw-1:0] last_beat = cw'(num_beats - 1);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;

   state_t            state, state_n;
   logic [cw-1:0]     cnt, cnt_n;
   logic [s_line-1:0] line_buf, line_buf_n, rdata_n;
   logic [31:0]       addr_n;
   logic [s_beat-1:0] wdata_n;
   logic              rd_n, wr_n, resp_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         line_buf    <= '0;
         pmem_rdata  <= '0;
         pmem_resp   <= 1'b0;
         burst_read  <= 1'b0;
         burst_write <= 1'b0;
         burst_addr  <= '0;
         burst_wdata <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         line_buf    <= line_buf_n;
         pmem_rdata  <= rdata_n;
         pmem_resp   <= resp_n;
         burst_read  <= rd_n;
         burst_write <= wr_n;
         burst_addr  <= addr_n;
         burst_wdata <= wdata_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      line_buf_n = line_buf;
      rdata_n    = pmem_rdata;
      addr_n     = burst_addr;
      wdata_n    = burst_wdata;
      rd_n       = burst_read;
      wr_n       = burst_write;
      resp_n     = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            // A write must win over a concurrent read (dirty victim goes first).
            if (pmem_write) begin
               state_n    = WR_BURST;
               addr_n     = {pmem_addr[31:s_offset], {s_offset{1'b0}}};
               line_buf_n = pmem_wdata;
               wdata_n    = pmem_wdata[s_beat-1:0];
               wr_n       = 1'b1;
            end else if (pmem_read) begin
               state_n = RD_BURST;
               addr_n  = {pmem_addr[31:s_offset], {s_offset{1'b0}}};
               rd_n    = 1'b1;
            end
         end
         RD_BURST: begin
            if (burst_resp) begin
               rdata_n[int'(cnt)*s_beat +: s_beat] = burst_rdata;
               cnt_n = cnt + cw'(1);
               if (cnt == last_beat) begin
                  rd_n    = 1'b0;
                  resp_n  = 1'b1;
                  state_n = RESP;
               end
            end
         end
         WR_BURST: begin
            if (burst_resp) begin
               // Counter wraps to 0 on the last beat, leaving beat 0 presented.
               cnt_n   = cnt + cw'(1);
               wdata_n = line_buf[int'(cnt_n)*s_beat +: s_beat];
               if (cnt == last_beat) begin
                  wr_n    = 1'b0;
                  resp_n  = 1'b1;
                  state_n = RESP;
               end
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench: stimulus pushes expected line responses into a queue, a
// separate monitor pops and compares on every pmem_resp pulse.
module tb_pmem_burst_responder;
   localparam int W = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          pmem_read, pmem_write;
   logic [31:0]   pmem_addr;
   logic [W-1:0]  pmem_wdata, pmem_rdata;
   logic          pmem_resp;
   logic          burst_read, burst_write;
   logic [31:0]   burst_addr;
   logic [63:0]   burst_wdata, burst_rdata;
   logic          burst_resp;

   int            errs = 0;
   int            checks = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  last_rd;

   pmem_burst_responder dut (
      .clk(clk), .reset(reset),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .burst_read(burst_read), .burst_write(burst_write),
      .burst_addr(burst_addr), .burst_wdata(burst_wdata),
      .burst_rdata(burst_rdata), .burst_resp(burst_resp)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic void fail_now(string nm);
      checks++;
      errs++;
      $display("FAIL %s", nm);
   endfunction

   // Every pulse must match a queued transaction; a pulse with nothing queued is spurious.
   always @(negedge clk) begin
      if (reset === 1'b0 && pmem_resp === 1'b1) begin
         if (exp_q.size() == 0) fail_now("spurious_resp: got pmem_resp=1 expected 0");
         else chk("resp_rdata", pmem_rdata, exp_q.pop_front());
      end
   end

   task automatic do_read(input logic [31:0] addr, input logic [3:0][63:0] beats,
                          input logic [15:0] mask);
      logic [31:0] al;
      int          b;
      bit          done;
      al      = addr & 32'hFFFF_FFE0;
      last_rd = beats;
      exp_q.push_back(beats);
      pmem_read = 1'b1;
      pmem_addr = addr;
      @(posedge clk); #1;
      pmem_addr = ~addr;
      b    = 0;
      done = 0;
      for (int i = 0; i < 16 && !done; i++) begin
         chk("rd_burst_read", burst_read, 1);
         chk("rd_burst_write", burst_write, 0);
         chk("rd_burst_addr", burst_addr, al);
         burst_resp  = mask[i];
         burst_rdata = beats[b];
         @(posedge clk); #1;
         if (mask[i]) begin
            b++;
            if (b == 4) done = 1;
         end
      end
      if (!done) fail_now("rd_timeout");
      burst_resp  = 1'b0;
      burst_rdata = '0;
      chk("rd_resp_latency", pmem_resp, 1);
      chk("rd_burst_read_clear", burst_read, 0);
      @(posedge clk); #1;
      pmem_read = 1'b0;
      pmem_addr = '0;
      chk("rd_resp_one_cycle", pmem_resp, 0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0][63:0] wb,
                           input logic [15:0] mask, input logic also_read);
      logic [31:0] al;
      int          b;
      bit          done;
      al = addr & 32'hFFFF_FFE0;
      exp_q.push_back(last_rd);
      pmem_write = 1'b1;
      pmem_read  = also_read;
      pmem_addr  = addr;
      pmem_wdata = wb;
      @(posedge clk); #1;
      pmem_addr = ~addr;
      b    = 0;
      done = 0;
      for (int i = 0; i < 16 && !done; i++) begin
         chk("wr_burst_write", burst_write, 1);
         chk("wr_burst_read", burst_read, 0);
         chk("wr_burst_addr", burst_addr, al);
         chk("wr_burst_wdata", burst_wdata, wb[b]);
         burst_resp = mask[i];
         @(posedge clk); #1;
         if (mask[i]) begin
            b++;
            if (b == 4) done = 1;
         end
      end
      if (!done) fail_now("wr_timeout");
      burst_resp = 1'b0;
      chk("wr_resp_latency", pmem_resp, 1);
      chk("wr_burst_write_clear", burst_write, 0);
      @(posedge clk); #1;
      pmem_write = 1'b0;
      pmem_read  = 1'b0;
      pmem_addr  = '0;
      chk("wr_resp_one_cycle", pmem_resp, 0);
   endtask

   initial begin
      reset = 1'b1;
      pmem_read = 1'b0; pmem_write = 1'b0; pmem_addr = '0; pmem_wdata = '0;
      burst_rdata = '0; burst_resp = 1'b0;
      last_rd = '0;
      #1;
      chk("rst_pmem_resp", pmem_resp, 0);
      chk("rst_burst_read", burst_read, 0);
      chk("rst_burst_write", burst_write, 0);
      chk("rst_burst_addr", burst_addr, 0);
      chk("rst_burst_wdata", burst_wdata, 0);
      chk("rst_pmem_rdata", pmem_rdata, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;

      // Basic read: 0x1234 aligns to 0x1220
      do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'h000F);
      // Basic write: 0x8000_003F aligns to 0x8000_0020, pmem_rdata untouched
      do_write(32'h8000_003F, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 16'h000F, 1'b0);
      // Stalled read: beats on cycles 1,4,5,9 of the burst
      do_read(32'h0000_2008, {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                              64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A}, 16'h0119);
      // Dirty miss: write-back then allocate, back to back
      do_write(32'h0000_0100, {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                               64'hCAFE_F00D_CAFE_F00D, 64'hDEAD_BEEF_DEAD_BEEF}, 16'h0035, 1'b0);
      do_read(32'h0000_0200, {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                              64'hFFFF_EEEE_DDDD_CCCC, 64'hBBBB_AAAA_9999_8888}, 16'h000F);
      // Read and write together: only the write is serviced
      do_write(32'h0000_3000, {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                               64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}, 16'h000F, 1'b1);

      // Stray burst_resp in IDLE must not start or advance anything
      burst_resp = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_stray_read", burst_read, 0);
         chk("idle_stray_write", burst_write, 0);
      end
      burst_resp = 1'b0;
      @(posedge clk); #1;
      do_read(32'h0000_4010, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 16'h000F);

      // Async reset after two beats of a read: no response, outputs cleared
      pmem_read = 1'b1;
      pmem_addr = 32'h0000_0040;
      @(posedge clk); #1;
      burst_resp  = 1'b1;
      burst_rdata = 64'h5555_5555_5555_5555;
      @(posedge clk); #1;
      burst_rdata = 64'h6666_6666_6666_6666;
      @(posedge clk); #1;
      burst_resp = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_pmem_resp", pmem_resp, 0);
      chk("mid_rst_burst_read", burst_read, 0);
      chk("mid_rst_burst_write", burst_write, 0);
      chk("mid_rst_burst_addr", burst_addr, 0);
      chk("mid_rst_burst_wdata", burst_wdata, 0);
      chk("mid_rst_pmem_rdata", pmem_rdata, 0);
      pmem_read = 1'b0;
      pmem_addr = '0;
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;
      last_rd = '0;
      do_read(32'h0000_0060, {64'h7777_0000_7777_0000, 64'h0000_6666_0000_6666,
                              64'h5050_5050_5050_5050, 64'h0505_0505_0505_0505}, 16'h000F);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
